// File: rtl/bht_pkg.sv
// Shared types for the branch history table and its update queue.
// Optional build macro BHT_UPDQ_BYPASS_EN is consumed by bht_update_queue.
package bht_pkg;

  localparam int unsigned BHT_VLEN       = 64;
  localparam int unsigned BHT_UPDQ_CNT_W = 16;

  typedef struct packed {
    logic [BHT_VLEN-1:0] pc;
    logic                taken;
  } bht_upd_entry_t;

  function automatic logic [BHT_UPDQ_CNT_W-1:0] bht_sat_inc(
    input logic [BHT_UPDQ_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bht_update_queue.sv
// Buffers resolved-branch outcomes ahead of the BHT update port.
// Define BHT_UPDQ_BYPASS_EN to forward into an empty queue with 0 latency.
module bht_update_queue
  import bht_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned VLEN  = BHT_VLEN
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      upd_valid_i,
  input  logic [VLEN-1:0]           upd_pc_i,
  input  logic                      upd_taken_i,
  input  logic                      flush_i,
  input  logic                      upd_ready_i,
  output logic                      bht_update_valid_o,
  output logic [VLEN-1:0]           bht_update_pc_o,
  output logic                      bht_update_taken_o,
  output logic                      full_o,
  output logic [BHT_UPDQ_CNT_W-1:0] drop_cnt_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  bht_upd_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       full_q, full_d;
  logic [BHT_UPDQ_CNT_W-1:0]  drop_q, drop_d;

  bht_upd_entry_t in_ent;
  bht_upd_entry_t head;
  bht_upd_entry_t out_ent;
  logic           empty;
  logic           at_cap;
  logic           out_valid;
  logic           deq;
  logic           rd;
  logic           wr;
  logic           drop;

  assign in_ent.pc    = BHT_VLEN'(upd_pc_i);
  assign in_ent.taken = upd_taken_i;
  assign head         = mem_q[rd_ptr_q];
  assign empty        = (cnt_q == '0);
  assign at_cap       = (cnt_q == CW'(DEPTH));

`ifdef BHT_UPDQ_BYPASS_EN
  logic byp;
  assign byp       = empty && upd_valid_i && !flush_i;
  assign out_valid = !empty || byp;
  assign out_ent   = byp ? in_ent : head;
  // A bypassed update taken by the BHT never touches storage.
  assign wr        = upd_valid_i && !flush_i
                   && (!at_cap || deq)
                   && !(byp && upd_ready_i);
`else
  assign out_valid = !empty;
  assign out_ent   = head;
  assign wr        = upd_valid_i && !flush_i
                   && (!at_cap || deq);
`endif

  assign deq  = out_valid && upd_ready_i;
  assign rd   = deq && !empty;
  assign drop = upd_valid_i && !flush_i
              && at_cap && !deq;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    if (wr) begin
      mem_d[wr_ptr_q] = in_ent;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (rd) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case (1'b1)
      wr && !rd: cnt_d = cnt_q + CW'(1);
      rd && !wr: cnt_d = cnt_q - CW'(1);
      default:   cnt_d = cnt_q;
    endcase
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end
    if (drop) begin
      drop_d = bht_sat_inc(drop_q);
    end
    full_d = (cnt_d == CW'(DEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      drop_q   <= drop_d;
    end
  end

  assign bht_update_valid_o = out_valid;
  assign bht_update_pc_o    = VLEN'(out_ent.pc);
  assign bht_update_taken_o = out_ent.taken;
  assign full_o             = full_q;
  assign drop_cnt_o         = drop_q;

endmodule

// File: tb/tb_bht_update_queue.sv
// Scoreboard bench for bht_update_queue against a queue-based shadow model.
// Honours BHT_UPDQ_BYPASS_EN the same way the design does.
module tb_bht_update_queue;
  import bht_pkg::*;

  localparam int DEPTH = 4;
  localparam int VLEN  = 64;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            upd_valid_i = 1'b0;
  logic [VLEN-1:0] upd_pc_i = '0;
  logic            upd_taken_i = 1'b0;
  logic            flush_i = 1'b0;
  logic            upd_ready_i = 1'b0;
  logic            bht_update_valid_o;
  logic [VLEN-1:0] bht_update_pc_o;
  logic            bht_update_taken_o;
  logic            full_o;
  logic [15:0]     drop_cnt_o;

  bht_update_queue #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .upd_valid_i        (upd_valid_i),
    .upd_pc_i           (upd_pc_i),
    .upd_taken_i        (upd_taken_i),
    .flush_i            (flush_i),
    .upd_ready_i        (upd_ready_i),
    .bht_update_valid_o (bht_update_valid_o),
    .bht_update_pc_o    (bht_update_pc_o),
    .bht_update_taken_o (bht_update_taken_o),
    .full_o             (full_o),
    .drop_cnt_o         (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  bht_upd_entry_t bht_shadow[$];
  bht_upd_entry_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  drop_model = 0;
  int  exp_drop = 0;
  bit  exp_valid = 0;
  bit  exp_full = 0;
  bit  mon_en = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Shadow model: decides this cycle's output and next-state from the rules.
  task automatic model_step();
    bht_upd_entry_t e;
    bit byp;
    bit deq;
    e.pc    = upd_pc_i;
    e.taken = upd_taken_i;
    byp = 0;
`ifdef BHT_UPDQ_BYPASS_EN
    byp = (bht_shadow.size() == 0) && upd_valid_i && !flush_i;
`endif
    exp_valid = (bht_shadow.size() > 0) || byp;
    exp_full  = (bht_shadow.size() == DEPTH);
    exp_drop  = drop_model;
    deq = exp_valid && upd_ready_i;
    if (deq) begin
      if (byp) exp_q.push_back(e);
      else     exp_q.push_back(bht_shadow.pop_front());
    end
    if (flush_i) begin
      bht_shadow.delete();
    end else if (upd_valid_i && !(byp && deq)) begin
      if (bht_shadow.size() < DEPTH) bht_shadow.push_back(e);
      else if (drop_model < 65535) drop_model++;
    end
  endtask

  task automatic drive(input bit v, input logic [63:0] pc, input bit tk,
                       input bit rdy, input bit fl);
    @(posedge clk_i);
    #1;
    upd_valid_i = v;
    upd_pc_i    = pc;
    upd_taken_i = tk;
    upd_ready_i = rdy;
    flush_i     = fl;
    model_step();
  endtask

  task automatic pulse_reset();
    @(posedge clk_i);
    #1;
    upd_valid_i = 0;
    upd_pc_i    = '0;
    upd_taken_i = 0;
    upd_ready_i = 0;
    flush_i     = 0;
    rst_ni      = 0;
    #1;
    check("rst_valid", 64'(bht_update_valid_o), 0);
    check("rst_pc",    bht_update_pc_o, 0);
    check("rst_taken", 64'(bht_update_taken_o), 0);
    check("rst_full",  64'(full_o), 0);
    check("rst_drop",  64'(drop_cnt_o), 0);
    bht_shadow.delete();
    exp_q.delete();
    drop_model = 0;
    rst_ni = 1;
    model_step();
  endtask

  always @(negedge clk_i) begin
    if (mon_en) begin
      check("valid", 64'(bht_update_valid_o), 64'(exp_valid));
      check("full",  64'(full_o), 64'(exp_full));
      check("drop",  64'(drop_cnt_o), 64'(exp_drop));
      if (bht_update_valid_o && upd_ready_i) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got pc %h, required no update",
                   bht_update_pc_o);
        end else begin
          bht_upd_entry_t e;
          e = exp_q.pop_front();
          check("sb_pc",    bht_update_pc_o, e.pc);
          check("sb_taken", 64'(bht_update_taken_o), 64'(e.taken));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check("init_valid", 64'(bht_update_valid_o), 0);
    check("init_pc",    bht_update_pc_o, 0);
    check("init_full",  64'(full_o), 0);
    check("init_drop",  64'(drop_cnt_o), 0);
    rst_ni = 1;
    mon_en = 1;

    // Single update, ready high.
    drive(1, 64'h8000_0010, 1, 1, 0);
`ifdef BHT_UPDQ_BYPASS_EN
    #1;
    check("t1_valid", 64'(bht_update_valid_o), 1);
    check("t1_pc",    bht_update_pc_o, 64'h8000_0010);
`else
    drive(0, 0, 0, 1, 0);
    #1;
    check("t1_valid", 64'(bht_update_valid_o), 1);
    check("t1_pc",    bht_update_pc_o, 64'h8000_0010);
`endif
    drive(0, 0, 0, 1, 0);
    #1;
    check("t1_empty", 64'(bht_update_valid_o), 0);

    // Fill with ready low, then overflow once.
    for (int i = 0; i < 4; i++) drive(1, 64'h100 + 64'(4 * i), i[0], 0, 0);
    drive(1, 64'h110, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    #1;
    check("t2_full", 64'(full_o), 1);
    check("t2_drop", 64'(drop_cnt_o), 1);
    check("t2_head", bht_update_pc_o, 64'h100);

    // Full with simultaneous dequeue accepts without a drop.
    drive(1, 64'h200, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    #1;
    check("t3_full", 64'(full_o), 1);
    check("t3_drop", 64'(drop_cnt_o), 1);
    check("t3_head", bht_update_pc_o, 64'h104);
    repeat (5) drive(0, 0, 0, 1, 0);

    // Flush with a concurrent input.
    for (int i = 0; i < 3; i++) drive(1, 64'h300 + 64'(4 * i), 1, 0, 0);
    drive(1, 64'h3F0, 1, 0, 1);
    drive(0, 0, 0, 0, 0);
    #1;
    check("t4_valid", 64'(bht_update_valid_o), 0);
    check("t4_drop",  64'(drop_cnt_o), 1);
    check("t4_full",  64'(full_o), 0);

    // Drop-counter saturation, then asynchronous reset.
    for (int i = 0; i < 4; i++) drive(1, 64'h400 + 64'(4 * i), 0, 0, 0);
    for (int i = 0; i < 70000; i++) drive(1, 64'h500, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    #1;
    check("t5_sat", 64'(drop_cnt_o), 64'hFFFF);
    pulse_reset();

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      logic [63:0] pc;
      pc = {32'($urandom), 32'($urandom)};
      drive(($urandom % 100) < 65, pc, 1'($urandom),
            ($urandom % 100) < 55, ($urandom % 128) == 0);
    end
    repeat (DEPTH + 2) drive(0, 0, 0, 1, 0);
    @(negedge clk_i);
    #1;
    check("final_sb",     64'(exp_q.size()), 0);
    check("final_shadow", 64'(bht_shadow.size()), 0);
    check("final_valid",  64'(bht_update_valid_o), 0);
    mon_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
